// File: rtl/ct_pkg.sv
// Shared definitions for the ct streaming fabric split and merge nodes.
// Holds the grant-index width helper, the eop-bit location default and lock states.
package ct_pkg;

  // The end-of-packet flag sits at this bit of every data word by default.
  localparam int CT_EOP_LOC = 0;

  typedef enum logic {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lk_st_e;

  // Index width that never collapses to zero, so NI=1 still gets a 1-bit index.
  function automatic int ct_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ct_rr_arb.sv
// Rotate-priority search over NI requesters starting at i_ptr, or a forced lock.
// Ports: i_req, i_ptr, i_lock, i_lock_idx in; o_grant_valid, o_grant_idx out.
module ct_rr_arb
  import ct_pkg::*;
#(
  parameter int NI = 2,
  parameter int WS = 1
)(
  input  logic [NI-1:0] i_req,
  input  logic [WS-1:0] i_ptr,
  input  logic          i_lock,
  input  logic [WS-1:0] i_lock_idx,
  output logic          o_grant_valid,
  output logic [WS-1:0] o_grant_idx
);

  logic [WS-1:0] w_idx;

  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_idx         = '0;
    if (i_lock) begin
      // A locked input is only granted while it actually requests,
      // so a mid-packet bubble grants nobody.
      o_grant_valid = i_req[i_lock_idx];
      o_grant_idx   = i_lock_idx;
    end else begin
      // Walk the rotation backwards so the closest
      // requester to i_ptr is the last (winning) write.
      for (int k = NI - 1; k >= 0; k--) begin
        w_idx = WS'((int'(i_ptr) + k) % NI);
        if (i_req[w_idx]) begin
          o_grant_valid = 1'b1;
          o_grant_idx   = w_idx;
        end
      end
    end
  end

endmodule

// File: rtl/ct_merge.sv
// N-to-1 packet-granular round-robin merge with one registered output stage.
// Ports: clk, reset (sync, active low), i_data/i_valid/o_ready up; o_data/o_valid/i_ready down.
module ct_merge
  import ct_pkg::*;
#(
  parameter  int NI      = 2,
  parameter  int WO      = 8,
  parameter  int EOP_LOC = CT_EOP_LOC,
  localparam int WS      = ct_clog2(NI)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [NI*WO-1:0] i_data,
  input  logic [NI-1:0]    i_valid,
  output logic [NI-1:0]    o_ready,
  output logic [WO-1:0]    o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  lk_st_e        r_st;
  lk_st_e        w_st_nx;
  logic [WS-1:0] r_lidx;
  logic [WS-1:0] w_lidx_nx;
  logic [WS-1:0] r_ptr;
  logic [WS-1:0] w_ptr_nx;
  logic [WO-1:0] r_data;
  logic          r_valid;

  logic          w_can_load;
  logic          w_lock;
  logic          w_gv;
  logic [WS-1:0] w_gi;
  logic          w_xfer;
  logic          w_eop;
  logic [WO-1:0] w_sel;
  logic [WO-1:0] w_in [NI];

  for (genvar i = 0; i < NI; i++) begin : g_unpack
    assign w_in[i] = i_data[i*WO +: WO];
  end

  assign w_can_load = !r_valid || i_ready;
  assign w_lock     = (r_st == LK_LOCKED);

  ct_rr_arb #(
    .NI (NI),
    .WS (WS)
  ) u_arb (
    .i_req         (i_valid),
    .i_ptr         (r_ptr),
    .i_lock        (w_lock),
    .i_lock_idx    (r_lidx),
    .o_grant_valid (w_gv),
    .o_grant_idx   (w_gi)
  );

  assign w_sel = w_in[w_gi];
  assign w_eop = w_sel[EOP_LOC];

  // Grant already implies i_valid of the granted input.
  assign w_xfer = reset && w_can_load && w_gv;

  always_comb begin
    o_ready = '0;
    if (w_xfer) o_ready[w_gi] = 1'b1;
  end

  always_comb begin
    w_st_nx   = r_st;
    w_lidx_nx = r_lidx;
    w_ptr_nx  = r_ptr;
    if (w_xfer) begin
      unique case (r_st)
        LK_IDLE: begin
          if (!w_eop && NI > 1) begin
            w_st_nx   = LK_LOCKED;
            w_lidx_nx = w_gi;
          end
        end
        LK_LOCKED: begin
          if (w_eop) w_st_nx = LK_IDLE;
        end
      endcase
      // Fairness advances only at packet boundaries.
      if (w_eop) begin
        w_ptr_nx = (w_gi == WS'(NI - 1)) ? '0 : w_gi + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_st   <= LK_IDLE;
      r_lidx <= '0;
      r_ptr  <= '0;
    end else begin
      r_st   <= w_st_nx;
      r_lidx <= w_lidx_nx;
      r_ptr  <= w_ptr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_sel;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule
